// File: rtl/latch_write_arbiter_pkg.sv
// Shared constants for the latch write arbiter: FSM state encoding and strobe counter width.
package latch_arb_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_ACK    = 3'd4;

    localparam int STROBE_CNT_W = 4;

endpackage

// File: rtl/latch_write_arbiter_if.sv
// Requester-side bus of the latch write arbiter: request/data in, grant/ack back.
interface latch_write_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 16
);
    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] wdata;
    logic [NREQ-1:0]        ack;
    logic [NREQ-1:0]        grant;

    modport master (output req, output wdata, input ack, input grant);
    modport slave  (input req, input wdata, output ack, output grant);
endinterface

// File: rtl/latch_write_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set req bit at or above rr_ptr, with wrap.
module rr_pick #(
    parameter int NREQ = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  pick,
    output logic             valid
);

    int j;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!valid && req[j]) begin
                pick[j] = 1'b1;
                valid   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/latch_write_arbiter.sv
// Sole driver of a shared D-latch bank: arbitrates requesters and sequences setup/strobe/hold.
// Build option LATCH_ARB_FIXED_PRIO_EN: lowest index always wins instead of round-robin.
//
// state  | meaning
// IDLE   | no write in flight; pick a requester and capture its word
// SETUP  | d settled, c low for one cycle
// STROBE | c high for STROBE_CYC cycles
// HOLD   | c low, d still held for one cycle
// ACK    | ack pulse to the owner; grant drops on exit
module latch_write_arbiter
    import latch_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DATA_W     = 16,
    parameter int STROBE_CYC = 1,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    latch_write_arbiter_if.slave  bus,
    output logic [DATA_W-1:0]     latch_d,
    output logic                  latch_c,
    output logic                  busy
);

    logic [2:0]              state;
    logic [NREQ-1:0]         grant_q;
    logic [NREQ-1:0]         ack_q;
    logic [STROBE_CNT_W-1:0] strobe_cnt;
    logic [IDX_W-1:0]        scan_base;
    logic [NREQ-1:0]         pick;
    logic                    pick_valid;
    logic [IDX_W-1:0]        pick_idx;

    assign bus.grant = grant_q;
    assign bus.ack   = ack_q;
    assign busy      = (state != ST_IDLE);

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (bus.req),
        .rr_ptr (scan_base),
        .pick   (pick),
        .valid  (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) pick_idx = IDX_W'(i);
        end
    end

`ifdef LATCH_ARB_FIXED_PRIO_EN
    assign scan_base = '0;
`else
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] rr_ptr;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) grant_idx = IDX_W'(i);
        end
    end

    // The just-served requester drops to lowest priority for the next scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (state == ST_ACK) begin
            rr_ptr <= (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    assign scan_base = rr_ptr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant_q    <= '0;
            ack_q      <= '0;
            latch_c    <= 1'b0;
            latch_d    <= '0;
            strobe_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_q <= pick;
                        latch_d <= bus.wdata[int'(pick_idx)*DATA_W +: DATA_W];
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    latch_c    <= 1'b1;
                    strobe_cnt <= STROBE_CNT_W'(STROBE_CYC - 1);
                    state      <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (strobe_cnt == '0) begin
                        latch_c <= 1'b0;
                        state   <= ST_HOLD;
                    end else begin
                        strobe_cnt <= strobe_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    ack_q <= grant_q;
                    state <= ST_ACK;
                end
                ST_ACK: begin
                    ack_q   <= '0;
                    grant_q <= '0;
                    state   <= ST_IDLE;
                end
                default: begin
                    latch_c <= 1'b0;
                    ack_q   <= '0;
                    grant_q <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/latch_write_arbiter.md
Name: latch_write_arbiter

Overview:
- Shares one bank of level-sensitive D latches (the storage cells of the shared register) among NREQ requesters.
- Selects one requester by round-robin and presents its word on the latch data lines.
- Sequences the latch enable through setup, strobe and hold phases so that d never changes while c is high, then acknowledges the requester.
- Sits between the bus-side register clients and the latch-based storage; it is the only driver of the latch c/d lines.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DATA_W, 16, latch word width.
- STROBE_CYC, 1, clk cycles the latch enable is held high (1..15).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester write request; held high until ack.
- wdata  in  NREQ*DATA_W  requester words; requester i uses slice [i*DATA_W +: DATA_W].
- ack  out  NREQ  one-cycle done pulse to the granted requester.
- grant  out  NREQ  one-hot owner of the write; 0 when idle.
- latch_d  out  DATA_W  registered data to the latch d inputs.
- latch_c  out  1  registered latch enable.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async): state=IDLE; grant=0; ack=0; latch_c=0; latch_d=0; rr_ptr=0; busy=0.
- The FSM has five states: IDLE, SETUP, STROBE, HOLD and ACK.
- IDLE
  - If any req bit is high, pick the first set bit scanning from rr_ptr upward with wrap.
  - Load grant one-hot, load latch_d from that requester's slice, go to SETUP.
  - With no request, remain in IDLE and keep latch_d unchanged.
- SETUP (1 cycle): latch_c=0 and latch_d stable. Go to STROBE.
- STROBE
  - latch_c=1 for exactly STROBE_CYC cycles, counted by a 4-bit counter.
  - Then latch_c=0 and go to HOLD.
- HOLD (1 cycle): latch_c=0 and latch_d still stable. Go to ACK.
- ACK (1 cycle)
  - ack[granted]=1.
  - rr_ptr = granted index + 1, wrapping NREQ-1 to 0.
  - grant clears on exit. Go to IDLE.
- Latency: from req sampled in IDLE to ack is 3 + STROBE_CYC cycles, i.e. 4 cycles at the default.
- Minimum spacing between successive grants is 4 + STROBE_CYC cycles, including the IDLE cycle.
- latch_d changes only on the IDLE→SETUP transition. latch_c is never high in IDLE, SETUP, HOLD or ACK.
- Requests arriving or dropping mid-sequence do not affect the current write.
  - A requester that drops req before ack still receives its ack.
  - Its data is the value captured in IDLE.
- Simultaneous requests: exactly one grant per sequence. Round-robin guarantees every requester is served within NREQ sequences.
- A requester still holding req in the cycle after its own ack is treated as a new request, at lowest round-robin priority.
- Reset mid-sequence: all outputs return to reset values immediately.
  - latch_c drops asynchronously, so the latch keeps whatever it had.
  - No ack is issued for the aborted write.

Optional Feature:
- Macro name: LATCH_ARB_FIXED_PRIO_EN.
- Defined: fixed priority is used; the lowest index wins. rr_ptr is not implemented and the scan always starts at bit 0.
- Undefined: round-robin as described above.
- Latency and phase sequencing are identical in both builds.

Decomposition:
- Shared package latch_arb_pkg holds:
  - the state encoding constants ST_IDLE=0, ST_SETUP=1, ST_STROBE=2, ST_HOLD=3, ST_ACK=4 (3 bits);
  - the STROBE counter width (4).
- One natural sub-module: rr_pick.
  - Combinational.
  - Inputs are req and rr_ptr; outputs are a one-hot pick and a valid flag.
  - Reused by the fixed-priority build with rr_ptr tied to 0.

Test Plan:
- Reset then single request: req=4'b0100, wdata slice2=16'hA5C3.
  - grant=4'b0100 in the cycle after req is sampled.
  - latch_d=16'hA5C3 one cycle before latch_c rises.
  - latch_c high for 1 cycle; ack[2] pulse 4 cycles after sampling.
  - The latch model reads 16'hA5C3.
- All four req high continuously: grant order 0,1,2,3,0.
  - Each ack is 5 cycles apart, and no two grant bits are ever set.
  - With LATCH_ARB_FIXED_PRIO_EN defined: 0,0,0…
- STROBE_CYC=3, req0 with data 16'h1234: latch_c high for exactly 3 cycles, ack at cycle 6.
  - A checker asserts latch_d is constant whenever latch_c=1.
- Requester 1 drops req during STROBE: ack[1] still pulses.
  - The latch holds the captured value, and the next grant goes to another pending requester.
- Assert rst during STROBE: latch_c=0 within the same cycle, with no ack.
  - After deassert with req=4'b0001, a full sequence completes normally.
- Back-to-back from the same requester: req3 held high alone.
  - Successive acks 5 cycles apart.
  - latch_d updates only at the grant boundary.
